// File: rtl/alu_exec_if.sv
// alu_exec_if: operation request and result/status bundle between the ALU decoder and alu_exec_unit.
interface alu_exec_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_SIZE = 6
);
    logic                  Start;
    logic [OP_SIZE-1:0]    Operation;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [4:0]            Shamt;
    logic [DATA_WIDTH-1:0] Result;
    logic                  Zero;
    logic                  BranchTaken;
    logic                  Busy;
    logic                  Done;
    logic [DATA_WIDTH-1:0] HI;
    logic [DATA_WIDTH-1:0] LO;

    modport master (
        output Start, Operation, A, B, Shamt,
        input  Result, Zero, BranchTaken, Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Operation, A, B, Shamt,
        output Result, Zero, BranchTaken, Busy, Done, HI, LO
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU ops plus 32-iteration signed MULT/DIV engines writing HI/LO.
// The engines work on magnitudes and fix up signs in a final FIX cycle.
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_SIZE = 6,
    parameter logic [OP_SIZE-1:0] ALU_ADD  = OP_SIZE'(0),
    parameter logic [OP_SIZE-1:0] ALU_SUB  = OP_SIZE'(1),
    parameter logic [OP_SIZE-1:0] ALU_AND  = OP_SIZE'(2),
    parameter logic [OP_SIZE-1:0] ALU_OR   = OP_SIZE'(3),
    parameter logic [OP_SIZE-1:0] ALU_NOR  = OP_SIZE'(4),
    parameter logic [OP_SIZE-1:0] ALU_SLT  = OP_SIZE'(5),
    parameter logic [OP_SIZE-1:0] ALU_SLL  = OP_SIZE'(6),
    parameter logic [OP_SIZE-1:0] ALU_SRL  = OP_SIZE'(7),
    parameter logic [OP_SIZE-1:0] ALU_LUI  = OP_SIZE'(8),
    parameter logic [OP_SIZE-1:0] ALU_BEQ  = OP_SIZE'(9),
    parameter logic [OP_SIZE-1:0] ALU_BGEZ = OP_SIZE'(10),
    parameter logic [OP_SIZE-1:0] ALU_MULT = OP_SIZE'(11),
    parameter logic [OP_SIZE-1:0] ALU_DIV  = OP_SIZE'(12),
    parameter logic [OP_SIZE-1:0] ALU_MFHI = OP_SIZE'(13),
    parameter logic [OP_SIZE-1:0] ALU_MFLO = OP_SIZE'(14)
) (
    input logic clk,
    input logic rst_n,
    alu_exec_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-1:0] acc_hi, acc_lo, mag_b, hi, lo, result, res;
    logic neg_q, neg_r, div0, is_div, zero, branch, busy, done, br, zr;
    logic [DATA_WIDTH:0] mul_sum, div_sh, div_diff;
    logic [2*DATA_WIDTH-1:0] prod;

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    assign div_sh   = {acc_hi, acc_lo[DATA_WIDTH-1]};
    assign div_diff = div_sh - {1'b0, mag_b};
    assign prod     = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

    always_comb begin
        res = '0;
        br = 1'b0;
        case (bus.Operation)
            ALU_ADD:  res = bus.A + bus.B;
            ALU_SUB:  res = bus.A - bus.B;
            ALU_AND:  res = bus.A & bus.B;
            ALU_OR:   res = bus.A | bus.B;
            ALU_NOR:  res = ~(bus.A | bus.B);
            ALU_SLT:  res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            ALU_SLL:  res = bus.B << bus.Shamt;
            ALU_SRL:  res = bus.B >> bus.Shamt;
            ALU_LUI:  res = {bus.B[15:0], {(DATA_WIDTH-16){1'b0}}};
            ALU_BEQ:  begin res = bus.A - bus.B; br = bus.A == bus.B; end
            ALU_BGEZ: begin res = bus.A; br = ~bus.A[DATA_WIDTH-1]; end
            ALU_MFHI: res = hi;
            ALU_MFLO: res = lo;
            default:  res = '0;
        endcase
        zr = bus.Operation == ALU_BEQ ? bus.A == bus.B : res == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mag_b <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0 <= 1'b0;
            is_div <= 1'b0;
            hi <= '0;
            lo <= '0;
            result <= '0;
            zero <= 1'b0;
            branch <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.Start) begin
                    if (bus.Operation == ALU_MULT || bus.Operation == ALU_DIV) begin
                        acc_hi <= '0;
                        acc_lo <= bus.A[DATA_WIDTH-1] ? -bus.A : bus.A;
                        mag_b <= bus.B[DATA_WIDTH-1] ? -bus.B : bus.B;
                        neg_q <= bus.A[DATA_WIDTH-1] ^ bus.B[DATA_WIDTH-1];
                        neg_r <= bus.A[DATA_WIDTH-1];
                        div0 <= bus.B == '0;
                        is_div <= bus.Operation == ALU_DIV;
                        cnt <= '0;
                        busy <= 1'b1;
                        state <= bus.Operation == ALU_DIV ? DIV : MUL;
                    end else begin
                        result <= res;
                        zero <= zr;
                        branch <= br;
                        done <= 1'b1;
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[DATA_WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    state <= cnt == CW'(DATA_WIDTH-1) ? FIX : MUL;
                end
                DIV: begin
                    // Restoring step: keep the trial difference only when it did not go negative
                    acc_hi <= div_diff[DATA_WIDTH] ? div_sh[DATA_WIDTH-1:0] : div_diff[DATA_WIDTH-1:0];
                    acc_lo <= {acc_lo[DATA_WIDTH-2:0], ~div_diff[DATA_WIDTH]};
                    cnt <= cnt + 1'b1;
                    state <= cnt == CW'(DATA_WIDTH-1) ? FIX : DIV;
                end
                FIX: begin
                    hi <= is_div ? (neg_r ? -acc_hi : acc_hi) : prod[2*DATA_WIDTH-1:DATA_WIDTH];
                    lo <= is_div ? (div0 ? '1 : neg_q ? -acc_lo : acc_lo) : prod[DATA_WIDTH-1:0];
                    busy <= 1'b0;
                    done <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Result = result;
    assign bus.Zero = zero;
    assign bus.BranchTaken = branch;
    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.HI = hi;
    assign bus.LO = lo;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution stage directly downstream of the ALU control decoder; consumes its registered Operation code with the two operands.
- Single-cycle ops (add/sub/logic/shift/compare/LUI/branch tests) complete in one clock.
- MULT/DIV run as 32-iteration signed shift-add / restoring-divide engines writing HI/LO; MFHI/MFLO read them back.
- Busy/Done handshake lets the multicycle control FSM stall on long ops.

Parameters:
- DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
- OP_SIZE, 6, width of Operation; ALU_* encodings come from the shared parameters include.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- Start  input  1  Operation/A/B/Shamt valid; sampled only when Busy=0
- Operation  input  OP_SIZE  ALU operation code (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI, ALU_BEQ, ALU_BGEZ, ALU_MULT, ALU_DIV, ALU_MFHI, ALU_MFLO)
- A  input  DATA_WIDTH  operand rs
- B  input  DATA_WIDTH  operand rt / sign-extended immediate
- Shamt  input  5  shift amount
- Result  output  DATA_WIDTH  registered result
- Zero  output  1  registered (Result==0), or (A==B) for ALU_BEQ
- BranchTaken  output  1  registered branch decision
- Busy  output  1  MULT/DIV in progress
- Done  output  1  one-cycle completion pulse
- HI  output  DATA_WIDTH  HI register
- LO  output  DATA_WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): Result=0, Zero=0, BranchTaken=0, Busy=0, Done=0, HI=0, LO=0, FSM=IDLE, iteration counter=0. Reset mid-MULT/DIV aborts immediately; no partial HI/LO write.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + Start + single-cycle op: at next edge, Result/Zero/BranchTaken update, Done=1 for exactly one cycle; stays IDLE. Back-to-back Starts give back-to-back Done pulses.
- Single-cycle ops (all mod 2^32, no overflow trap):
  - ADD: A+B. SUB: A-B. AND, OR, NOR bitwise.
  - SLT: signed A<B gives 1, else 0.
  - SLL: B<<Shamt. SRL: logical B>>Shamt.
  - LUI: {B[15:0],16'h0}.
  - BEQ: Result=A-B, Zero=BranchTaken=(A==B).
  - BGEZ: Result=A, BranchTaken=~A[31].
  - MFHI: Result=HI. MFLO: Result=LO.
  - Non-branch ops: BranchTaken=0.
  - Unknown code: Result=0, Zero=1, Done still pulses.
- IDLE + Start + MULT/DIV, at edge k:
  - Latch |A|, |B| and the result signs; Busy=1; go to MUL/DIV; counter=0.
  - Edges k+1..k+32: one iteration each.
    - MUL: shift-add, 64-bit product.
    - DIV: restoring, 1 quotient bit per cycle.
  - Edge k+32: go to FIX.
  - Edge k+33:
    - Sign-correct the result.
    - MULT: {HI,LO}=signed 64-bit product.
    - DIV: LO=quotient truncated toward zero; HI=remainder carrying the sign of A.
    - Busy=0, Done=1 for one cycle; go to IDLE.
  - Result/Zero/BranchTaken unchanged by MULT/DIV.
- DIV with B=0: no iteration change in timing (still 34 cycles). HI=A, LO=32'hFFFFFFFF.
- DIV 0x80000000 / -1: LO=0x80000000, HI=0.
- Start while Busy=1: ignored entirely. Inputs are not latched, and a queued op is not accepted.
- HI/LO change only at FIX or reset. MFHI/MFLO issued the cycle Done pulses for MULT/DIV return the new values.

Test Plan:
- ADD A=7 B=5, Start 1 cycle -> next cycle Result=12, Zero=0, Done=1 one cycle; SUB 5-5 -> Result=0, Zero=1.
- SLT A=0xFFFFFFFF B=1 -> Result=1; SLL B=1 Shamt=31 -> 0x80000000; LUI B=0x1234 -> 0x12340000.
- MULT A=-3 B=5 -> Busy 33 cycles, Done at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFF1; then MFLO -> Result=0xFFFFFFF1.
- DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV A=9 B=0 -> HI=9, LO=0xFFFFFFFF, same 34-cycle latency.
- Start ADD during MULT Busy -> no Done/Result change until MULT completes; rst_n low at iteration 10 -> Busy=0, HI=LO=0 immediately, no Done.
- BEQ A=B=0x55 -> Zero=1, BranchTaken=1; BGEZ A=0x80000000 -> BranchTaken=0; BGEZ A=0 -> BranchTaken=1.
